// File: rtl/tri_bus_ctrl_pkg.sv
// Shared types for the tri-state bus sequencer.
// State encoding and phase counter width.
package tri_bus_ctrl_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_TURN = 2'd2,
        ST_RD   = 2'd3
    } state_e;

endpackage

// File: rtl/tri_bus_ctrl_if.sv
// Requester and pad-side signals of the tri-state bus sequencer.
// slave is the sequencer view, master the requester/pad view.
interface tri_bus_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             req;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             ack;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic [WIDTH-1:0] bus_do;
    logic             bus_oe;
    logic             bus_stb;
    logic             bus_rnw;
    logic [WIDTH-1:0] bus_di;

    modport slave (
        input  req,
        input  we,
        input  wdata,
        input  bus_di,
        output ack,
        output rdata,
        output busy,
        output bus_do,
        output bus_oe,
        output bus_stb,
        output bus_rnw
    );

    modport master (
        output req,
        output we,
        output wdata,
        output bus_di,
        input  ack,
        input  rdata,
        input  busy,
        input  bus_do,
        input  bus_oe,
        input  bus_stb,
        input  bus_rnw
    );

endinterface

// File: rtl/tri_bus_ctrl_phase_cnt.sv
// Loadable down-counter with zero flag for timing pad phases.
// load has priority over dec; dec at zero is never issued by the user.
module tri_bus_ctrl_phase_cnt
    import tri_bus_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tri_bus_ctrl.sv
// Shared bidirectional bus sequencer: req/ack to timed strobe cycles
// with turnaround so driver and device never overlap on the wire.
module tri_bus_ctrl
    import tri_bus_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WR_CYC   = 2,
    parameter int RD_CYC   = 2,
    parameter int TURN_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    tri_bus_ctrl_if.slave bif
);

    localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD =
        (TURN_CYC == 0) ? '0 : CNT_W'(TURN_CYC - 1);

    state_e           state_q, state_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic             stb_q, stb_d;
    logic             rnw_q, rnw_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] do_q, do_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    tri_bus_ctrl_phase_cnt u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        do_d     = do_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                // a req still high during ack belongs to the old transfer
                if (bif.req && !ack_q) begin
                    cnt_load = 1'b1;
                    if (bif.we) begin
                        state_d = ST_WR;
                        cnt_val = WR_LD;
                        do_d    = bif.wdata;
                    end else begin
                        state_d = ST_RD;
                        cnt_val = RD_LD;
                    end
                end
            end
            ST_WR: begin
                if (cnt_zero) begin
                    ack_d = 1'b1;
                    if (TURN_CYC == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_TURN;
                        cnt_load = 1'b1;
                        cnt_val  = TURN_LD;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                    rdata_d = bif.bus_di;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        oe_d   = (state_d == ST_WR);
        stb_d  = (state_d == ST_WR) || (state_d == ST_RD);
        rnw_d  = (state_d != ST_WR);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            stb_q   <= 1'b0;
            rnw_q   <= 1'b1;
            rdata_q <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
            stb_q   <= stb_d;
            rnw_q   <= rnw_d;
            rdata_q <= rdata_d;
            do_q    <= do_d;
        end
    end

    assign bif.ack     = ack_q;
    assign bif.busy    = busy_q;
    assign bif.rdata   = rdata_q;
    assign bif.bus_do  = do_q;
    assign bif.bus_oe  = oe_q;
    assign bif.bus_stb = stb_q;
    assign bif.bus_rnw = rnw_q;

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Directed bench for tri_bus_ctrl: default timing on dut_a,
// WR_CYC=1/TURN_CYC=0 on dut_b, ack scoreboard on both.
module tb_tri_bus_ctrl;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_oe_a  = -1;
    int first_rd_a = -1;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    tri_bus_ctrl_if #(.WIDTH(32)) ifa ();
    tri_bus_ctrl_if #(.WIDTH(32)) ifb ();

    tri_bus_ctrl #(
        .WIDTH    (32),
        .WR_CYC   (2),
        .RD_CYC   (2),
        .TURN_CYC (1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bif (ifa)
    );

    tri_bus_ctrl #(
        .WIDTH    (32),
        .WR_CYC   (1),
        .RD_CYC   (2),
        .TURN_CYC (0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bif (ifb)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic rd, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic rd, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        qb.push_back(e);
    endtask

    // one cycle: sample at negedge, run invariants and scoreboards
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("contention_a", 32'(ifa.bus_oe & ifa.bus_rnw), 32'd0);
        chk("contention_b", 32'(ifb.bus_oe & ifb.bus_rnw), 32'd0);
        if (ifa.bus_oe === 1'b1) last_oe_a = cyc;
        if (first_rd_a < 0 && ifa.bus_stb === 1'b1 &&
            ifa.bus_rnw === 1'b1) first_rd_a = cyc;
        if (ifa.ack === 1'b1) begin
            chk("ack_expected_a", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                if (e.rd) chk("rdata_a", ifa.rdata, e.data);
            end
        end
        if (ifb.ack === 1'b1) begin
            chk("ack_expected_b", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                if (e.rd) chk("rdata_b", ifb.rdata, e.data);
            end
        end
    endtask

    task automatic run_until_ack(output int c, input int max);
        bit got;
        got = 1'b0;
        c   = -1;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (ifa.ack === 1'b1) begin
                got = 1'b1;
                c   = cyc;
            end
        end
        chk("ack_timeout_a", 32'(got), 32'd1);
    endtask

    initial begin
        int c0;
        int c1;
        int c2;

        rst        = 1'b1;
        ifa.req    = 1'b0;
        ifa.we     = 1'b0;
        ifa.wdata  = '0;
        ifa.bus_di = '0;
        ifb.req    = 1'b0;
        ifb.we     = 1'b0;
        ifb.wdata  = '0;
        ifb.bus_di = '0;

        // reset state
        tick();
        tick();
        chk("rst_ack", 32'(ifa.ack), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_oe", 32'(ifa.bus_oe), 32'd0);
        chk("rst_stb", 32'(ifa.bus_stb), 32'd0);
        chk("rst_rnw", 32'(ifa.bus_rnw), 32'd1);
        chk("rst_do", ifa.bus_do, 32'h0);
        chk("rst_rdata", ifa.rdata, 32'h0);
        chk("rst_rnw_b", 32'(ifb.bus_rnw), 32'd1);
        rst = 1'b0;
        tick();

        // single write, defaults
        ifa.req   = 1'b1;
        ifa.we    = 1'b1;
        ifa.wdata = 32'hA5A5_0001;
        push_a(1'b0, 32'hA5A5_0001);
        tick();
        chk("wr1_oe", 32'(ifa.bus_oe), 32'd1);
        chk("wr1_do", ifa.bus_do, 32'hA5A5_0001);
        chk("wr1_stb", 32'(ifa.bus_stb), 32'd1);
        chk("wr1_rnw", 32'(ifa.bus_rnw), 32'd0);
        chk("wr1_ack", 32'(ifa.ack), 32'd0);
        ifa.wdata = 32'hFFFF_0000;
        tick();
        chk("wr2_oe", 32'(ifa.bus_oe), 32'd1);
        chk("wr2_do", ifa.bus_do, 32'hA5A5_0001);
        tick();
        chk("wr_ack", 32'(ifa.ack), 32'd1);
        chk("wr_ack_oe", 32'(ifa.bus_oe), 32'd0);
        chk("wr_ack_busy", 32'(ifa.busy), 32'd1);
        ifa.req = 1'b0;
        tick();
        chk("wr_idle_busy", 32'(ifa.busy), 32'd0);
        chk("wr_idle_ack", 32'(ifa.ack), 32'd0);
        chk("wr_idle_do", ifa.bus_do, 32'hA5A5_0001);

        // single read
        ifa.bus_di = 32'h1234_5678;
        ifa.req    = 1'b1;
        ifa.we     = 1'b0;
        push_a(1'b1, 32'h1234_5678);
        tick();
        chk("rd1_stb", 32'(ifa.bus_stb), 32'd1);
        chk("rd1_rnw", 32'(ifa.bus_rnw), 32'd1);
        chk("rd1_oe", 32'(ifa.bus_oe), 32'd0);
        chk("rd1_ack", 32'(ifa.ack), 32'd0);
        tick();
        chk("rd2_stb", 32'(ifa.bus_stb), 32'd1);
        chk("rd2_oe", 32'(ifa.bus_oe), 32'd0);
        tick();
        chk("rd_ack", 32'(ifa.ack), 32'd1);
        chk("rd_rdata", ifa.rdata, 32'h1234_5678);
        chk("rd_ack_stb", 32'(ifa.bus_stb), 32'd0);
        ifa.req = 1'b0;
        tick();

        // write then read with req held through ack
        first_rd_a = -1;
        ifa.req    = 1'b1;
        ifa.we     = 1'b1;
        ifa.wdata  = 32'hCAFE_0002;
        push_a(1'b0, 32'hCAFE_0002);
        run_until_ack(c0, 10);
        ifa.we     = 1'b0;
        ifa.bus_di = 32'h0BAD_0003;
        push_a(1'b1, 32'h0BAD_0003);
        run_until_ack(c1, 10);
        ifa.req = 1'b0;
        chk("wr_rd_gap", 32'(first_rd_a - last_oe_a >= 3), 32'd1);
        chk("wr_rd_spacing", 32'(c1 - c0), 32'd4);
        tick();

        // back-to-back reads; ack-cycle req is ignored, so
        // three idle/strobe cycles lie between the two acks
        ifa.bus_di = 32'h11;
        ifa.req    = 1'b1;
        ifa.we     = 1'b0;
        push_a(1'b1, 32'h11);
        run_until_ack(c1, 10);
        ifa.bus_di = 32'h22;
        push_a(1'b1, 32'h22);
        tick();
        chk("b2b_hold1", ifa.rdata, 32'h11);
        chk("b2b_noack", 32'(ifa.ack), 32'd0);
        tick();
        chk("b2b_hold2", ifa.rdata, 32'h11);
        run_until_ack(c2, 10);
        ifa.req = 1'b0;
        chk("b2b_spacing", 32'(c2 - c1), 32'd4);
        tick();
        tick();
        chk("b2b_hold3", ifa.rdata, 32'h22);

        // reset in the middle of a write
        ifa.req   = 1'b1;
        ifa.we    = 1'b1;
        ifa.wdata = 32'hDEAD_0004;
        tick();
        chk("abort_oe_pre", 32'(ifa.bus_oe), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_oe", 32'(ifa.bus_oe), 32'd0);
        chk("abort_stb", 32'(ifa.bus_stb), 32'd0);
        chk("abort_busy", 32'(ifa.busy), 32'd0);
        chk("abort_ack", 32'(ifa.ack), 32'd0);
        rst     = 1'b0;
        ifa.req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_ack", 32'(ifa.ack), 32'd0);
        end

        // WR_CYC=1, TURN_CYC=0 on dut_b
        ifb.req   = 1'b1;
        ifb.we    = 1'b1;
        ifb.wdata = 32'h5A5A_0005;
        push_b(1'b0, 32'h5A5A_0005);
        tick();
        chk("b_wr_oe", 32'(ifb.bus_oe), 32'd1);
        chk("b_wr_do", ifb.bus_do, 32'h5A5A_0005);
        tick();
        chk("b_ack", 32'(ifb.ack), 32'd1);
        chk("b_ack_oe", 32'(ifb.bus_oe), 32'd0);
        chk("b_ack_busy", 32'(ifb.busy), 32'd0);
        ifb.wdata = 32'h5A5A_0006;
        push_b(1'b0, 32'h5A5A_0006);
        tick();
        chk("b_gap_ack", 32'(ifb.ack), 32'd0);
        chk("b_gap_oe", 32'(ifb.bus_oe), 32'd0);
        tick();
        chk("b_wr2_oe", 32'(ifb.bus_oe), 32'd1);
        chk("b_wr2_do", ifb.bus_do, 32'h5A5A_0006);
        chk("b_wr2_busy", 32'(ifb.busy), 32'd1);
        ifb.req = 1'b0;
        tick();
        chk("b_ack2", 32'(ifb.ack), 32'd1);
        tick();
        chk("b_idle_busy", 32'(ifb.busy), 32'd0);
        chk("b_idle_do", ifb.bus_do, 32'h5A5A_0006);

        chk("sb_empty_a", 32'(qa.size()), 32'd0);
        chk("sb_empty_b", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
